jtframe_neptuno_joy: RTL and testbench



---
 rtl/jtframe_neptuno_joy_pkg.sv | 50 +++++
 rtl/jtframe_neptuno_joy_deb.sv | 38 +++
 rtl/jtframe_neptuno_joy.sv | 128 ++++++++++++
 tb/tb_jtframe_neptuno_joy.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_neptuno_joy_pkg.sv
// Shared types and constants for the NeptUNO DB9 serial joystick reader.
package jtframe_neptuno_joy_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_SWAP,
    ST_SETTLE
  } state_t;

  // Bit positions inside the active-high joystick word
  localparam int RIGHT = 0;
  localparam int LEFT  = 1;
  localparam int DOWN  = 2;
  localparam int UP    = 3;
  localparam int BTN_B = 4;
  localparam int BTN_C = 5;
  localparam int BTN_A = 6;
  localparam int START = 7;

  localparam int PORT_BITS  = 6;
  localparam int PHASE_BITS = 12;

  // Field positions inside one port's slice of a scanned phase
  localparam int FLD_U     = 0;
  localparam int FLD_D     = 1;
  localparam int FLD_L     = 2;
  localparam int FLD_R     = 3;
  localparam int FLD_B     = 4;
  localparam int FLD_C     = 5;
  localparam int FLD_A     = 4;
  localparam int FLD_START = 5;

  function automatic logic [15:0] pad_word(input logic [PORT_BITS-1:0] hi,
                                           input logic [PORT_BITS-1:0] lo);
    logic [15:0] w;
    w        = '0;
    w[RIGHT] = hi[FLD_R];
    w[LEFT]  = hi[FLD_L];
    w[DOWN]  = hi[FLD_D];
    w[UP]    = hi[FLD_U];
    w[BTN_B] = hi[FLD_B];
    w[BTN_C] = hi[FLD_C];
    w[BTN_A] = lo[FLD_A];
    w[START] = lo[FLD_START];
    return w;
  endfunction

endpackage

// File: rtl/jtframe_neptuno_joy_deb.sv
// Compare-and-hold filter: a frame reaches the outputs only when it repeats
// the previous candidate, so single-frame glitches never show up.
module jtframe_neptuno_joy_deb (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic [15:0] cand1,
  input  logic [15:0] cand2,
  output logic [15:0] joy1,
  output logic [15:0] joy2,
  output logic        done
);

  logic [15:0] prev1_reg;
  logic [15:0] prev2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev1_reg <= '0;
      prev2_reg <= '0;
      joy1      <= '0;
      joy2      <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stb) begin
        prev1_reg <= cand1;
        prev2_reg <= cand2;
        if (cand1 == prev1_reg && cand2 == prev2_reg) begin
          joy1 <= cand1;
          joy2 <= cand2;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtframe_neptuno_joy.sv
// NeptUNO serial reader for two 3-button Mega Drive pads behind a 12-bit 165 chain.
// Define JTFRAME_JOY_DEBOUNCE_EN to hold back frames that differ from the previous one.
module jtframe_neptuno_joy
  import jtframe_neptuno_joy_pkg::*;
#(
  parameter int CLKDIV = 8,
  parameter int SETTLE = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic        JOY_SELECT,
  input  logic        JOY_DATA,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int DW = $clog2(CLKDIV);
  localparam int SW = $clog2(SETTLE + 1);

  logic [DW-1:0]         div_reg;
  logic                  tick;
  state_t                state_reg;
  logic [3:0]            bc_reg;
  logic [SW-1:0]         settle_reg;
  logic [PHASE_BITS-1:0] sreg;
  logic [PHASE_BITS-1:0] hreg;
  logic                  pend_reg;
  logic                  commit;
  logic [15:0]           cand [2];

  assign tick = (div_reg == DW'(CLKDIV - 1));

  // The frame is released at the end of the settle time that follows the
  // SELECT=0 phase, so both phases are complete and the next frame starts clean.
  assign commit = tick && (state_reg == ST_SETTLE) &&
                  (settle_reg == SW'(SETTLE - 1)) && pend_reg;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      div_reg    <= '0;
      state_reg  <= ST_LOAD;
      bc_reg     <= '0;
      settle_reg <= '0;
      sreg       <= '0;
      hreg       <= '0;
      pend_reg   <= 1'b0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD   <= 1'b1;
      JOY_SELECT <= 1'b1;
    end else begin
      div_reg  <= tick ? '0 : div_reg + DW'(1);
      JOY_LOAD <= (state_reg != ST_LOAD);
      JOY_CLK  <= (state_reg == ST_SHIFT_HI);
      if (tick) begin
        case (state_reg)
          ST_LOAD: begin
            bc_reg    <= '0;
            state_reg <= ST_SHIFT_LO;
          end
          ST_SHIFT_LO: begin
            sreg[bc_reg] <= ~JOY_DATA;
            state_reg    <= ST_SHIFT_HI;
          end
          ST_SHIFT_HI: begin
            if (bc_reg == 4'(PHASE_BITS - 1)) begin
              state_reg <= ST_SWAP;
            end else begin
              bc_reg    <= bc_reg + 4'd1;
              state_reg <= ST_SHIFT_LO;
            end
          end
          ST_SWAP: begin
            if (JOY_SELECT) hreg <= sreg;
            pend_reg   <= ~JOY_SELECT;
            JOY_SELECT <= ~JOY_SELECT;
            settle_reg <= '0;
            state_reg  <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_reg == SW'(SETTLE - 1)) begin
              pend_reg  <= 1'b0;
              state_reg <= ST_LOAD;
            end else begin
              settle_reg <= settle_reg + SW'(1);
            end
          end
          default: state_reg <= ST_LOAD;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign cand[gi] = pad_word(hreg[gi*PORT_BITS +: PORT_BITS],
                               sreg[gi*PORT_BITS +: PORT_BITS]);
  end

`ifdef JTFRAME_JOY_DEBOUNCE_EN
  jtframe_neptuno_joy_deb u_deb (
    .clk   (clk_sys),
    .rst   (rst),
    .stb   (commit),
    .cand1 (cand[0]),
    .cand2 (cand[1]),
    .joy1  (joystick1),
    .joy2  (joystick2),
    .done  (frame_done)
  );
`else
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
      if (commit) begin
        joystick1 <= cand[0];
        joystick2 <= cand[1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_jtframe_neptuno_joy.sv
// Bench for jtframe_neptuno_joy: a 12-bit 165 chain model fed from pad button sets,
// a frame-level expectation model, and directed steps (honours JTFRAME_JOY_DEBOUNCE_EN).
module tb_jtframe_neptuno_joy;

  localparam int FRAME  = 448;
  localparam int FRAME4 = 224;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        joy_clk, joy_load, joy_select, joy_data;
  logic [15:0] joystick1, joystick2;
  logic        frame_done;

  logic        joy_clk4, joy_load4, joy_select4;
  logic        joy_data4 = 1'b1;
  logic [15:0] joystick1_4, joystick2_4;
  logic        frame_done4;

  jtframe_neptuno_joy #(.CLKDIV(8), .SETTLE(2)) dut (
    .clk_sys    (clk),
    .rst        (rst),
    .JOY_CLK    (joy_clk),
    .JOY_LOAD   (joy_load),
    .JOY_SELECT (joy_select),
    .JOY_DATA   (joy_data),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  jtframe_neptuno_joy #(.CLKDIV(4), .SETTLE(2)) dut4 (
    .clk_sys    (clk),
    .rst        (rst),
    .JOY_CLK    (joy_clk4),
    .JOY_LOAD   (joy_load4),
    .JOY_SELECT (joy_select4),
    .JOY_DATA   (joy_data4),
    .joystick1  (joystick1_4),
    .joystick2  (joystick2_4),
    .frame_done (frame_done4)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Pressed buttons per port, in joystick word layout (active high)
  logic [7:0] btn1 = 8'h00;
  logic [7:0] btn2 = 8'h00;

  // Lines a 3-button pad drives (active low); SELECT low shows A/Start, L/R read low
  function automatic logic [5:0] pad_lines(input logic [7:0] b, input logic sel);
    if (sel) return ~{b[5], b[4], b[0], b[1], b[2], b[3]};
    else     return ~{b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
  endfunction

  logic [11:0] chain_reg = '1;
  logic        clk_q = 1'b0;
  always @(posedge clk) begin
    clk_q <= joy_clk;
    if (!joy_load)
      chain_reg <= {pad_lines(btn2, joy_select), pad_lines(btn1, joy_select)};
    else if (joy_clk && !clk_q)
      chain_reg <= {1'b1, chain_reg[11:1]};
  end
  assign joy_data = chain_reg[0];

  // Frame-level model: buttons seen during a frame appear at the next frame boundary
  int          n = 0;
  logic [15:0] exp1 = '0, exp2 = '0, prev1 = '0, prev2 = '0;
  logic        exp_done = 1'b0;
  logic [7:0]  snap1 = '0, snap2 = '0;
  always @(posedge clk) begin
    if (rst) begin
      n <= 0; exp1 <= '0; exp2 <= '0; prev1 <= '0; prev2 <= '0; exp_done <= 1'b0;
    end else begin
      n <= n + 1;
      exp_done <= 1'b0;
      if (n % FRAME == 0) begin
        snap1 <= btn1;
        snap2 <= btn2;
      end
      if ((n + 1) % FRAME == 0) begin
        if (!DEB || ({8'h00, snap1} == prev1 && {8'h00, snap2} == prev2)) begin
          exp1 <= {8'h00, snap1};
          exp2 <= {8'h00, snap2};
          exp_done <= 1'b1;
        end
        prev1 <= {8'h00, snap1};
        prev2 <= {8'h00, snap2};
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_joystick1", joystick1, exp1);
    check("cyc_joystick2", joystick2, exp2);
    check("cyc_frame_done", frame_done, exp_done);
    if (frame_done) $display("frame_done t=%0t joystick1=%04h joystick2=%04h", $time, joystick1, joystick2);
  end

  task automatic wait_frame(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_done !== 1'b1 && cyc < limit);
  endtask

  task automatic step(input string name, input logic [7:0] b1, input logic [7:0] b2,
                      input int frames, input logic [15:0] e1, input logic [15:0] e2);
    btn1 = b1;
    btn2 = b2;
    repeat (frames * FRAME) @(negedge clk);
    $display("step %s: joystick1=%04h joystick2=%04h", name, joystick1, joystick2);
    check({name, "_j1"}, joystick1, e1);
    check({name, "_j2"}, joystick2, e2);
  endtask

  bit done4 = 1'b0;
  initial begin
    int t;
    int fd[$];
    int cr[$];
    logic prev;
    t = 0;
    prev = 1'b0;
    wait (rst == 1'b0);
    while (t < 1000 && (fd.size() < 2 || cr.size() < 2)) begin
      @(negedge clk);
      t++;
      if (frame_done4) fd.push_back(t);
      if (joy_clk4 && !prev) cr.push_back(t);
      prev = joy_clk4;
    end
    $display("clkdiv4: frame_done at %0d, JOY_CLK rises %0d", fd.size() > 0 ? fd[0] : -1, cr.size());
    check("div4_first_done", fd.size() > 0 ? fd[0] : -1, FRAME4);
    check("div4_frame_len", fd.size() > 1 ? fd[1] - fd[0] : -1, FRAME4);
    check("div4_clk_period", cr.size() > 1 ? cr[1] - cr[0] : -1, 8);
    check("div4_joystick1", joystick1_4, 16'h0000);
    done4 = 1'b1;
  end

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_joy_clk", joy_clk, 1'b0);
    check("rst_joy_load", joy_load, 1'b1);
    check("rst_joy_select", joy_select, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;

    wait_frame(1000, cyc);
    $display("first frame: cycle %0d joystick1=%04h joystick2=%04h", cyc, joystick1, joystick2);
    check("first_done_cycle", cyc, FRAME);
    check("first_j1", joystick1, 16'h0000);
    check("first_j2", joystick2, 16'h0000);

    step("up",       8'h08, 8'h00, 2, 16'h0008, 16'h0000);
    step("a_start",  8'h00, 8'hC0, 2, 16'h0000, 16'h00C0);
    step("all",      8'hFF, 8'hFF, 2, 16'h00FF, 16'h00FF);
    step("idle",     8'h00, 8'h00, 2, 16'h0000, 16'h0000);
    step("glitch",   8'h10, 8'h00, 1, DEB ? 16'h0000 : 16'h0010, 16'h0000);
    step("post_glt", 8'h00, 8'h00, 1, 16'h0000, 16'h0000);

    btn1 = 8'h01;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("mid-frame reset: joystick1=%04h select=%0b", joystick1, joy_select);
    check("midrst_j1", joystick1, 16'h0000);
    check("midrst_j2", joystick2, 16'h0000);
    check("midrst_select", joy_select, 1'b1);
    check("midrst_load", joy_load, 1'b1);
    rst = 1'b0;
    wait_frame(1200, cyc);
    $display("after reset: cycle %0d joystick1=%04h", cyc, joystick1);
    check("midrst_done_cycle", cyc, DEB ? 2 * FRAME : FRAME);
    check("midrst_right", joystick1, 16'h0001);

    for (int i = 0; i < 1000 && !done4; i++) @(negedge clk);
    check("div4_finished", done4, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
